// File: rtl/freqdiv_sync_gen.sv
// freqdiv_sync_gen: periodic one-cycle sync pulse generator that re-phases a
// bank of integer frequency dividers. The pulse period is run-time writable;
// writes made while running are held back until the current period ends, so
// no runt periods are ever produced.
module freqdiv_sync_gen #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_DEF = 12,
  parameter int ARM_DLY    = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             resync_req,
  input  logic             period_we,
  input  logic [CNT_W-1:0] period_din,
  output logic             sync,
  output logic [CNT_W-1:0] phase,
  output logic             locked,
  output logic             err
);

  localparam int ARM_W = (ARM_DLY > 1) ? $clog2(ARM_DLY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t             state;
  logic [ARM_W-1:0]   arm_cnt;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   pend_val;
  logic               pend;

  logic               din_ok;
  logic               good_we;
  logic               bad_we;
  logic               wrap;

  // Decode the period write and the end-of-period condition
  assign din_ok  = (period_din >= CNT_W'(2));
  assign good_we = period_we && din_ok;
  assign bad_we  = period_we && !din_ok;
  assign wrap    = (phase == (period - CNT_W'(1)));

  // Single state machine holding the phase counter, period, shadow and flags
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      period   <= CNT_W'(PERIOD_DEF);
      pend_val <= '0;
      pend     <= 1'b0;
      sync     <= 1'b0;
      phase    <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else if (!en) begin
      // Leaving RUN ends the in-flight period, so a held-back write becomes
      // the period used after the next enable.
      state  <= IDLE;
      sync   <= 1'b0;
      phase  <= '0;
      locked <= 1'b0;
      if (pend) begin
        period <= pend_val;
      end
      pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sync    <= 1'b0;
          phase   <= '0;
          locked  <= 1'b0;
          state   <= ARM;
          arm_cnt <= ARM_W'(ARM_DLY - 1);
          if (good_we) begin
            period <= period_din;
          end
          if (bad_we) begin
            err <= 1'b1;
          end
        end

        ARM: begin
          if (arm_cnt == '0) begin
            state  <= RUN;
            sync   <= 1'b1;
            phase  <= '0;
            locked <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt - ARM_W'(1);
            sync    <= 1'b0;
            phase   <= '0;
            locked  <= 1'b0;
          end
          if (good_we) begin
            period <= period_din;
          end
          if (bad_we) begin
            err <= 1'b1;
          end
        end

        RUN: begin
          locked <= 1'b1;
          if (resync_req) begin
            // Forced realignment also closes the current period
            sync  <= 1'b1;
            phase <= '0;
            if (pend) begin
              period <= pend_val;
            end
            pend <= 1'b0;
          end else if (wrap) begin
            // A write landing on the wrap edge starts the new period at once
            sync  <= 1'b1;
            phase <= '0;
            if (good_we) begin
              period <= period_din;
            end else if (pend) begin
              period <= pend_val;
            end
            pend <= 1'b0;
            if (bad_we) begin
              err <= 1'b1;
            end
          end else begin
            sync  <= 1'b0;
            phase <= phase + CNT_W'(1);
            if (good_we) begin
              pend_val <= period_din;
              pend     <= 1'b1;
            end
            if (bad_we) begin
              err <= 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          sync   <= 1'b0;
          phase  <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/freqdiv_sync_gen.md
Name: freqdiv_sync_gen

Overview:
Upstream companion to the integer frequency dividers. It generates the periodic one-cycle `sync` pulse that re-phases every divider in a clock bank, so that dividers with different division factors stay phase-aligned. The pulse period is set to a common multiple of the downstream division factors. The period can be changed at run time without producing runt periods. A software or host request can force an immediate realignment.

Parameters:
CNT_W, 16, width of the period register and the phase counter.
PERIOD_DEF, 12, sync period in clk_in cycles after reset; must be >= 2 and < 2^CNT_W.
ARM_DLY, 2, number of cycles spent in ARM between enable and the first sync pulse; must be >= 1.

Ports:
clk_in  input  1  single clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  level enable; high = generate sync pulses.
resync_req  input  1  one-cycle request to realign immediately.
period_we  input  1  write strobe for period_din.
period_din  input  CNT_W  new sync period in cycles.
sync  output  1  registered one-cycle pulse, fed to the dividers' sync inputs.
phase  output  CNT_W  registered position within the current period; 0 when sync is high.
locked  output  1  high while in RUN.
err  output  1  sticky flag: an illegal period was written.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; sync = 0; phase = 0; locked = 0; err = 0; period = PERIOD_DEF; pending-period flag cleared.
- Reset has priority over every other input, including when asserted mid-RUN.
- Priority below reset: en = 0, then resync_req, then period_we, then normal counting.
- IDLE:
  - sync = 0, phase = 0, locked = 0.
  - If en = 1 at edge k, enter ARM with arm_cnt = ARM_DLY - 1.
- ARM:
  - Outputs are held as in IDLE; arm_cnt decrements each cycle.
  - The edge that sees arm_cnt == 0 enters RUN and sets sync = 1, phase = 0, locked = 1.
  - Net effect: the first sync pulse is registered at edge k + ARM_DLY.
- RUN:
  - phase increments by 1 each cycle.
  - When phase == period - 1, the next edge sets phase = 0 and sync = 1.
  - Otherwise sync = 0.
  - Sync pulses are therefore exactly `period` cycles apart.
- en = 0 in any state: next edge enters IDLE and clears sync, phase and locked.
  - A later re-enable passes through ARM again.
  - Period and err are retained.
- resync_req in RUN: next edge forces phase = 0 and sync = 1; locked stays 1.
  - This edge also commits any pending period.
  - resync_req is ignored in IDLE and ARM.
  - resync_req in the same cycle as a natural wrap produces a single sync pulse.
- Legal period write (period_we = 1 and period_din >= 2):
  - In IDLE or ARM, the new period takes effect immediately.
  - In RUN, the value is stored in a shadow register and marked pending. It is committed at the next wrap (phase period-1 -> 0) or the next resync, so the in-flight period always completes at its old length.
  - A second write before commit overwrites the pending value.
- Illegal period write (period_din < 2): ignored; err = 1 and stays set until rst.
- period_we in the same cycle as the wrap edge: the new value is used for the period starting at that wrap.

Test Plan:
1. Defaults; rst released; en = 1 sampled at edge 0 -> sync pulses at edges 2, 14, 26; phase counts 0..11 repeatedly; locked = 1 from edge 2.
2. In RUN, write period_din = 5 while phase = 3 -> next sync still 12 cycles after the previous one; subsequent syncs 5 cycles apart; phase wraps at 4.
3. resync_req while phase = 7 -> next edge sync = 1, phase = 0; following sync 12 cycles later. resync_req together with a natural wrap -> exactly one pulse.
4. Write period_din = 1, then 0 -> err = 1 and stays 1; period stays 12 and pulse spacing is unchanged. err clears only on rst.
5. Drop en mid-RUN -> next edge sync = 0, phase = 0, locked = 0. Re-raise en -> first sync ARM_DLY (= 2) cycles later, using the last legal period.
6. Assert rst in RUN together with resync_req and period_we (period_din = 7) -> next edge all outputs 0, period = 12, pending write discarded.
